// File: rtl/matmul_sequencer.sv
// Walks C = A x W as i/j/k loops, feeding one A/W element pair at a time to an external
// sequential multiplier and emitting each signed dot product on a valid/ready result port.
module matmul_sequencer #(
    parameter int N       = 8,
    parameter int ROWS    = 402,
    parameter int COLUMNS = 26,
    parameter int W_COL   = 128,
    localparam int ACC_W  = 2*N + $clog2(COLUMNS),
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW     = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
    localparam int JW     = (W_COL > 1) ? $clog2(W_COL) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [RW-1:0]           a_row,
    output logic [CW-1:0]           a_col,
    input  logic signed [N-1:0]     a_data,
    output logic [CW-1:0]           w_row,
    output logic [JW-1:0]           w_col,
    input  logic signed [N-1:0]     w_data,
    output logic signed [N-1:0]     multiplicand,
    output logic signed [N-1:0]     multiplier,
    output logic                    mul_start,
    input  logic                    mul_ready,
    input  logic signed [2*N-1:0]   product,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RW-1:0]           res_row,
    output logic [JW-1:0]           res_col,
    output logic signed [ACC_W-1:0] res_data
);

    localparam int TMO = 2*N + 4;
    localparam int TW  = $clog2(TMO + 1);

    typedef enum logic [3:0] {IDLE, FETCH, LOAD, START, SKIP, WAIT, ACC, EMIT, FIN} state_t;

    state_t                  state, state_nxt;
    logic [RW-1:0]           i_q, i_h;
    logic [JW-1:0]           j_q, j_h;
    logic [CW-1:0]           k_q, k_h;
    logic signed [ACC_W-1:0] acc;
    logic [TW-1:0]           wait_cnt;
    logic                    last_i, last_j, last_k, timeout;

    function automatic logic signed [ACC_W-1:0] sext_product(input logic signed [2*N-1:0] p);
        return ACC_W'(p);
    endfunction

    assign last_i  = (i_q == RW'(ROWS - 1));
    assign last_j  = (j_q == JW'(W_COL - 1));
    assign last_k  = (k_q == CW'(COLUMNS - 1));
    assign timeout = (state == WAIT) && !mul_ready && (wait_cnt == TW'(TMO - 1));

    assign busy      = (state != IDLE);
    assign done      = (state == FIN) || timeout;
    assign mul_start = (state == START) && mul_ready;
    assign res_valid = (state == EMIT);
    assign res_row   = res_valid ? i_q : '0;
    assign res_col   = res_valid ? j_q : '0;
    assign res_data  = res_valid ? acc : '0;

    // Addresses are live only in FETCH and otherwise replay the last fetched location.
    assign a_row = (state == FETCH) ? i_q : i_h;
    assign a_col = (state == FETCH) ? k_q : k_h;
    assign w_row = (state == FETCH) ? k_q : k_h;
    assign w_col = (state == FETCH) ? j_q : j_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go) state_nxt = FETCH;
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = START;
            START: if (mul_ready) state_nxt = SKIP;
            SKIP:  state_nxt = WAIT;
            WAIT: begin
                if (mul_ready)    state_nxt = ACC;
                else if (timeout) state_nxt = IDLE;
            end
            ACC:   state_nxt = last_k ? EMIT : FETCH;
            EMIT:  if (res_ready) state_nxt = (last_i && last_j) ? FIN : FETCH;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            i_h          <= '0;
            j_h          <= '0;
            k_h          <= '0;
            acc          <= '0;
            error        <= 1'b0;
            wait_cnt     <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                        acc   <= '0;
                        error <= 1'b0;
                    end
                end
                FETCH: begin
                    i_h <= i_q;
                    j_h <= j_q;
                    k_h <= k_q;
                end
                LOAD: begin
                    multiplicand <= a_data;
                    multiplier   <= w_data;
                end
                SKIP: wait_cnt <= '0;
                WAIT: begin
                    if (!mul_ready) wait_cnt <= wait_cnt + 1'b1;
                    if (timeout)    error    <= 1'b1;
                end
                ACC: begin
                    acc <= acc + sext_product(product);
                    if (!last_k) k_q <= k_q + 1'b1;
                end
                // j is the middle loop: it wraps first and carries into i.
                EMIT: begin
                    if (res_ready) begin
                        acc <= '0;
                        k_q <= '0;
                        j_q <= last_j ? '0 : j_q + 1'b1;
                        if (last_j) i_q <= last_i ? '0 : i_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: 2x2x2 product with memory and sequential-multiplier models.
module tb_matmul_sequencer;
    localparam int N = 8, ROWS = 2, COLUMNS = 2, W_COL = 2;
    localparam int ACC_W = 2*N + $clog2(COLUMNS);
    localparam int PW = 2*N;
    localparam int NRES = ROWS * W_COL;

    logic clk = 0, rst_n = 0, go = 0;
    logic busy, done, error, mul_start, mul_ready, res_valid, res_ready = 1;
    logic [0:0] a_row, a_col, w_row, w_col, res_row, res_col;
    logic signed [N-1:0] a_data = 0, w_data = 0, multiplicand, multiplier;
    logic signed [PW-1:0] product = 0;
    logic signed [ACC_W-1:0] res_data;

    matmul_sequencer #(.N(N), .ROWS(ROWS), .COLUMNS(COLUMNS), .W_COL(W_COL)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done), .error(error),
        .a_row(a_row), .a_col(a_col), .a_data(a_data), .w_row(w_row), .w_col(w_col),
        .w_data(w_data), .multiplicand(multiplicand), .multiplier(multiplier),
        .mul_start(mul_start), .mul_ready(mul_ready), .product(product),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_col(res_col), .res_data(res_data));

    always #5 clk = ~clk;

    int a_mem [ROWS][COLUMNS];
    int w_mem [COLUMNS][W_COL];
    int exp_data [NRES];
    int got_row [16], got_col [16], got_data [16];
    int n_cmp = 0, n_bad = 0;

    // Synchronous-read memories: data appears one cycle after the address.
    always @(posedge clk) begin
        a_data <= N'(a_mem[a_row][a_col]);
        w_data <= N'(w_mem[w_row][w_col]);
    end

    // Sequential multiplier: busy for a random latency after start, ready otherwise.
    bit busy_m = 0, stall = 0, hang = 0;
    int cnt_m = 0, lat_lo = 1, lat_hi = 8;
    assign mul_ready = hang ? 1'b0 : (busy_m ? (cnt_m == 0) : !stall);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 0;
            cnt_m  <= 0;
        end else if (mul_start) begin
            busy_m  <= 1;
            cnt_m   <= $urandom_range(lat_hi, lat_lo);
            product <= PW'(int'(multiplicand) * int'(multiplier));
        end else if (busy_m) begin
            if (cnt_m == 0) busy_m <= 0;
            else            cnt_m  <= cnt_m - 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic build_expected();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < W_COL; j++) begin
                int s = 0;
                for (int k = 0; k < COLUMNS; k++) s += a_mem[i][k] * w_mem[k][j];
                exp_data[i*W_COL + j] = s;
            end
    endtask

    task automatic load_basic();
        a_mem = '{'{1, 2}, '{3, 4}};
        w_mem = '{'{5, 6}, '{7, 8}};
    endtask

    // Starts one product and records every accepted result until Done has been seen.
    task automatic run_op(input int go_at, input bit rand_ready,
                          output int nres, output int ndone, output bit tmo);
        int cyc = 0, post = 0;
        nres = 0; ndone = 0; tmo = 0;
        for (int r = 0; r < 16; r++) begin
            got_row[r] = -1; got_col[r] = -1; got_data[r] = 32'h7fffffff;
        end
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        while (post < 4) begin
            if (cyc >= 3000) begin tmo = 1; break; end
            @(negedge clk);
            go        = (cyc == go_at);
            stall     = ($urandom_range(3, 0) == 0);
            res_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            #1;
            if (res_valid && res_ready) begin
                if (nres < 16) begin
                    got_row[nres] = int'(res_row); got_col[nres] = int'(res_col);
                    got_data[nres] = int'(res_data);
                end
                nres++;
            end
            if (done) ndone++;
            if (ndone > 0) post++;
            cyc++;
        end
        go = 0; stall = 0; res_ready = 1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({busy, done, error, mul_start, res_valid} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b, required 00000", {busy, done, error, mul_start, res_valid});
        end
        n_cmp++;
        if ({a_row, a_col, w_row, w_col, res_row, res_col} !== 6'b0 || res_data !== 0) begin
            n_bad++; $display("FAIL reset_addr_res: got addr/res %b data %0d, required 0", {a_row, a_col, w_row, w_col, res_row, res_col}, res_data);
        end
        n_cmp++;
        if (multiplicand !== 0 || multiplier !== 0) begin
            n_bad++; $display("FAIL reset_operands: got %0d,%0d, required 0,0", multiplicand, multiplier);
        end
        @(negedge clk); rst_n = 1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_autostart: busy %b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int nres, ndone; bit tmo;
        int want [NRES] = '{19, 22, 43, 50};
        load_basic(); lat_lo = 1; lat_hi = 8;
        run_op(-1, 0, nres, ndone, tmo);
        n_cmp++;
        if (tmo || nres !== NRES || ndone !== 1) begin
            n_bad++; $display("FAIL basic_counts: tmo %0d results %0d dones %0d, required 0 %0d 1", tmo, nres, ndone, NRES);
        end
        for (int r = 0; r < NRES; r++) begin
            n_cmp++;
            if (got_row[r] !== r / W_COL || got_col[r] !== r % W_COL || got_data[r] !== want[r]) begin
                n_bad++; $display("FAIL basic_res[%0d]: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                                  r, got_row[r], got_col[r], got_data[r], r / W_COL, r % W_COL, want[r]);
            end
        end
    endtask

    task automatic test_extremes();
        int nres, ndone; bit tmo;
        a_mem = '{'{-128, -128}, '{-128, -128}};
        w_mem = '{'{-128, -128}, '{-128, -128}};
        run_op(-1, 1, nres, ndone, tmo);
        for (int r = 0; r < NRES; r++) begin
            n_cmp++;
            if (nres !== NRES || got_data[r] !== 32768) begin
                n_bad++; $display("FAIL extreme_pos[%0d]: got %0d (results %0d), required 32768", r, got_data[r], nres);
            end
        end
        a_mem = '{'{-1, 2}, '{$urandom_range(255, 0) - 128, $urandom_range(255, 0) - 128}};
        w_mem = '{'{3, $urandom_range(255, 0) - 128}, '{-4, $urandom_range(255, 0) - 128}};
        build_expected();
        run_op(-1, 1, nres, ndone, tmo);
        n_cmp++;
        if (got_data[0] !== -11) begin
            n_bad++; $display("FAIL extreme_neg: got %0d, required -11", got_data[0]);
        end
        for (int r = 1; r < NRES; r++) begin
            n_cmp++;
            if (got_data[r] !== exp_data[r]) begin
                n_bad++; $display("FAIL extreme_rest[%0d]: got %0d, required %0d", r, got_data[r], exp_data[r]);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0, nres = 1, ndone = 0;
        int want [NRES] = '{19, 22, 43, 50};
        load_basic(); lat_lo = 2; lat_hi = 4;
        res_ready = 0;
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        while (!res_valid && cyc < 300) begin @(negedge clk); #1; cyc++; end
        n_cmp++;
        if (!res_valid) begin
            n_bad++; $display("FAIL bp_first_valid: res_valid %b after %0d cycles, required 1", res_valid, cyc);
        end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 19 || res_row !== 0 || res_col !== 0 ||
                mul_start !== 1'b0 || a_col !== 1'b1 || w_row !== 1'b1 || w_col !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold[%0d]: valid %b data %0d row %0d col %0d start %b addr %b, required 1 19 0 0 0 0110",
                                  c, res_valid, res_data, res_row, res_col, mul_start, {a_row, a_col, w_row, w_col});
            end
            @(negedge clk); #1;
        end
        res_ready = 1;
        @(negedge clk); #1;
        n_cmp++;
        if ({a_row, a_col, w_row, w_col} !== 4'b0001) begin
            n_bad++; $display("FAIL bp_next_fetch: addr %b, required 0001", {a_row, a_col, w_row, w_col});
        end
        cyc = 0;
        while (ndone == 0 && cyc < 500) begin
            if (res_valid && res_ready) begin
                if (nres < NRES && res_data !== want[nres]) begin
                    n_bad++; $display("FAIL bp_res[%0d]: got %0d, required %0d", nres, res_data, want[nres]);
                end
                n_cmp++;
                nres++;
            end
            if (done) ndone++;
            @(negedge clk); #1; cyc++;
        end
        n_cmp++;
        if (nres !== NRES || ndone !== 1) begin
            n_bad++; $display("FAIL bp_finish: results %0d dones %0d, required %0d 1", nres, ndone, NRES);
        end
    endtask

    task automatic test_timeout();
        int cyc = 0, n = 0;
        load_basic(); lat_lo = 2; lat_hi = 4;
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        #1;
        while (!mul_start && cyc < 100) begin @(negedge clk); #1; cyc++; end
        @(posedge clk); #1; hang = 1;
        while (n < 100) begin
            @(negedge clk); #1; n++;
            if (done) break;
        end
        n_cmp++;
        if (n !== 2*N + 5) begin
            n_bad++; $display("FAIL timeout_latency: done after %0d cycles from start, required %0d", n, 2*N + 5);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL timeout_flags: error %b busy %b done %b, required 1 0 0", error, busy, done);
        end
        hang = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++; $display("FAIL timeout_sticky: error %b, required 1", error);
        end
        @(negedge clk); go = 1;
        @(negedge clk); go = 0; #1;
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL timeout_clear: error %b busy %b, required 0 1", error, busy);
        end
        cyc = 0;
        while (busy && cyc < 500) begin @(negedge clk); #1; cyc++; end
        n_cmp++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            n_bad++; $display("FAIL timeout_rerun: busy %b error %b, required 0 0", busy, error);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0, starts = 0, nres, ndone; bit tmo;
        int want [NRES] = '{19, 22, 43, 50};
        load_basic(); lat_lo = 6; lat_hi = 6;
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        while (starts < 3 && cyc < 300) begin
            @(negedge clk); #1; cyc++;
            if (mul_start) starts++;
        end
        @(negedge clk); @(negedge clk); #2;
        rst_n = 0; #1;
        n_cmp++;
        if ({busy, done, error, mul_start, res_valid} !== 5'b0 || {a_row, a_col, w_row, w_col, res_row, res_col} !== 6'b0 ||
            res_data !== 0 || multiplicand !== 0 || multiplier !== 0 || starts !== 3) begin
            n_bad++; $display("FAIL midreset_zero: ctrl %b addr %b data %0d ops %0d,%0d starts %0d, required all 0 with 3 starts",
                              {busy, done, error, mul_start, res_valid}, {a_row, a_col, w_row, w_col, res_row, res_col},
                              res_data, multiplicand, multiplier, starts);
        end
        @(negedge clk); rst_n = 1;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mul_start !== 1'b0) begin
            n_bad++; $display("FAIL midreset_idle: busy %b start %b, required 0 0", busy, mul_start);
        end
        lat_lo = 1; lat_hi = 8;
        run_op(-1, 0, nres, ndone, tmo);
        for (int r = 0; r < NRES; r++) begin
            n_cmp++;
            if (nres !== NRES || got_row[r] !== r / W_COL || got_col[r] !== r % W_COL || got_data[r] !== want[r]) begin
                n_bad++; $display("FAIL midreset_rerun[%0d]: got (%0d,%0d)=%0d results %0d, required (%0d,%0d)=%0d",
                                  r, got_row[r], got_col[r], got_data[r], nres, r / W_COL, r % W_COL, want[r]);
            end
        end
    endtask

    task automatic test_go_while_busy();
        int nres, ndone; bit tmo;
        load_basic(); build_expected();
        run_op(6, 0, nres, ndone, tmo);
        n_cmp++;
        if (tmo || nres !== NRES || ndone !== 1) begin
            n_bad++; $display("FAIL gobusy_counts: tmo %0d results %0d dones %0d, required 0 %0d 1", tmo, nres, ndone, NRES);
        end
        for (int r = 0; r < NRES; r++) begin
            n_cmp++;
            if (got_row[r] !== r / W_COL || got_col[r] !== r % W_COL || got_data[r] !== exp_data[r]) begin
                n_bad++; $display("FAIL gobusy_res[%0d]: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                                  r, got_row[r], got_col[r], got_data[r], r / W_COL, r % W_COL, exp_data[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nres, ndone; bit tmo;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < ROWS; i++)
                for (int k = 0; k < COLUMNS; k++) a_mem[i][k] = int'($urandom_range(255, 0)) - 128;
            for (int k = 0; k < COLUMNS; k++)
                for (int j = 0; j < W_COL; j++) w_mem[k][j] = int'($urandom_range(255, 0)) - 128;
            build_expected();
            lat_lo = 1; lat_hi = $urandom_range(8, 1);
            run_op(-1, 1, nres, ndone, tmo);
            n_cmp++;
            if (tmo || nres !== NRES || ndone !== 1 || error !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_counts: tmo %0d results %0d dones %0d error %b, required 0 %0d 1 0",
                                  it, tmo, nres, ndone, error, NRES);
            end
            for (int r = 0; r < NRES; r++) begin
                n_cmp++;
                if (got_row[r] !== r / W_COL || got_col[r] !== r % W_COL || got_data[r] !== exp_data[r]) begin
                    n_bad++; $display("FAIL rand%0d_res[%0d]: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                                      it, r, got_row[r], got_col[r], got_data[r], r / W_COL, r % W_COL, exp_data[r]);
                end
            end
        end
    endtask

    initial begin
        a_mem = '{'{0, 0}, '{0, 0}};
        w_mem = '{'{0, 0}, '{0, 0}};
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_go_while_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
